// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage LoongArch pipeline.
//
// Sits between execute and write-back. It latches the execute-to-memory bus
// and collects the synchronous data-SRAM read data one cycle after execute
// issued the request. Load data is sign- or zero-extended here, and the
// memory-to-write-back bus is forwarded. It also reports bypass and CSR
// hazard information to decode, and tells execute when an exception is in
// flight so that execute can suppress stores.
//
// Ports:
//   clk, resetn        clock (rising edge), synchronous active-low reset
//   ex_mem_valid       execute offers an instruction
//   mem_allowin        this stage can take an instruction this cycle
//   ex_mem_bus[189:0]  execute-to-memory bus
//   data_sram_rdata    SRAM read data, valid in the first cycle after accept
//   mem_wb_valid       instruction offered to write-back
//   wb_allowin         write-back accepts this cycle
//   mem_wb_bus[183:0]  memory-to-write-back bus
//   mem_id_bus[52:0]   bypass / CSR-hazard information for decode
//   mem_ex             syscall or ertn present in this stage
//   wb_ex, ertn_flush  flush requests from write-back
module mem_stage (
    input  logic         clk,
    input  logic         resetn,
    input  logic         ex_mem_valid,
    output logic         mem_allowin,
    input  logic [189:0] ex_mem_bus,
    input  logic [31:0]  data_sram_rdata,
    output logic         mem_wb_valid,
    input  logic         wb_allowin,
    output logic [183:0] mem_wb_bus,
    output logic [52:0]  mem_id_bus,
    output logic         mem_ex,
    input  logic         wb_ex,
    input  logic         ertn_flush
);

    logic         mem_valid_q, mem_valid_d;
    logic         first_cycle_q, first_cycle_d;
    logic [189:0] bus_q, bus_d;
    logic [31:0]  rdata_hold_q, rdata_hold_d;

    logic         ready_go;
    logic         accept;
    logic         flush;

    // Fields of the latched execute-to-memory bus
    logic         gr_we;
    logic         res_from_mem;
    logic [2:0]   mem_type;
    logic [1:0]   addr_low2;
    logic [4:0]   dest;
    logic [31:0]  pc;
    logic [31:0]  inst;
    logic [31:0]  result;
    logic         csr_we;
    logic         csr_re;
    logic [13:0]  csr_num;
    logic [31:0]  csr_wmask;
    logic [31:0]  csr_wvalue;
    logic         ertn;
    logic         syscall;

    logic [31:0]  rdata_eff;
    logic [7:0]   byte_data;
    logic [15:0]  half_data;
    logic [31:0]  load_data;
    logic [31:0]  final_result;

    assign {gr_we, res_from_mem, mem_type, addr_low2, dest, pc, inst, result,
            csr_we, csr_re, csr_num, csr_wmask, csr_wvalue, ertn, syscall} = bus_q;

    // Handshake: the stage always completes in one cycle, so it only blocks
    // when it holds an instruction that write-back refuses.
    always_comb begin
        ready_go     = 1'b1;
        mem_wb_valid = mem_valid_q & ready_go;
        mem_allowin  = ~mem_valid_q | (mem_wb_valid & wb_allowin);
        accept       = ex_mem_valid & mem_allowin;
        flush        = wb_ex | ertn_flush;
    end

    // Next-state logic. A flush beats a simultaneous accept. The SRAM read
    // data is only guaranteed for the first cycle after accept, so it is
    // copied into rdata_hold then and used for the rest of any stall.
    always_comb begin
        mem_valid_d   = mem_valid_q;
        first_cycle_d = accept;
        bus_d         = bus_q;
        rdata_hold_d  = rdata_hold_q;
        if (flush) begin
            mem_valid_d = 1'b0;
        end else if (mem_allowin) begin
            mem_valid_d = ex_mem_valid;
        end
        if (accept) begin
            bus_d = ex_mem_bus;
        end
        if (first_cycle_q) begin
            rdata_hold_d = data_sram_rdata;
        end
    end

    // Control state, with synchronous reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid_q   <= 1'b0;
            first_cycle_q <= 1'b0;
        end else begin
            mem_valid_q   <= mem_valid_d;
            first_cycle_q <= first_cycle_d;
        end
    end

    // Datapath state is meaningless while mem_valid is low, so it has no reset
    always_ff @(posedge clk) begin
        bus_q        <= bus_d;
        rdata_hold_q <= rdata_hold_d;
    end

    // Load alignment and extension. Size 11 is reserved and behaves as word.
    // addr_low2[0] is ignored for half loads.
    always_comb begin
        rdata_eff = first_cycle_q ? data_sram_rdata : rdata_hold_q;
        byte_data = rdata_eff[{addr_low2, 3'b000} +: 8];
        half_data = addr_low2[1] ? rdata_eff[31:16] : rdata_eff[15:0];
        case (mem_type[1:0])
            2'b00:   load_data = mem_type[2] ? {24'd0, byte_data}
                                             : {{24{byte_data[7]}}, byte_data};
            2'b01:   load_data = mem_type[2] ? {16'd0, half_data}
                                             : {{16{half_data[15]}}, half_data};
            default: load_data = rdata_eff;
        endcase
        final_result = res_from_mem ? load_data : result;
    end

    // Outputs. dest and final_result go to decode even when the stage is
    // empty; the bypass flag and csr_re carry the validity qualification.
    always_comb begin
        mem_wb_bus = {gr_we, dest, pc, inst, final_result, csr_we, csr_re,
                      csr_num, csr_wmask, csr_wvalue, ertn, syscall};
        mem_id_bus = {mem_valid_q & gr_we, dest, final_result,
                      mem_valid_q & csr_re, csr_num};
        mem_ex     = mem_valid_q & (syscall | ertn);
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage.
//
// The stimulus process drives one cycle at a time. Whenever it knows an
// instruction enters the stage, it pushes that instruction into a scoreboard
// queue. A separate monitor runs on the falling edge. It compares every
// output against the instruction at the head of the queue, and pops that
// instruction when the instruction leaves the stage through a handoff, a
// flush, or a reset.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         resetn;
    logic         ex_mem_valid;
    logic         mem_allowin;
    logic [189:0] ex_mem_bus;
    logic [31:0]  data_sram_rdata;
    logic         mem_wb_valid;
    logic         wb_allowin;
    logic [183:0] mem_wb_bus;
    logic [52:0]  mem_id_bus;
    logic         mem_ex;
    logic         wb_ex;
    logic         ertn_flush;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .ex_mem_valid    (ex_mem_valid),
        .mem_allowin     (mem_allowin),
        .ex_mem_bus      (ex_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_wb_valid    (mem_wb_valid),
        .wb_allowin      (wb_allowin),
        .mem_wb_bus      (mem_wb_bus),
        .mem_id_bus      (mem_id_bus),
        .mem_ex          (mem_ex),
        .wb_ex           (wb_ex),
        .ertn_flush      (ertn_flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        gr_we;
        logic        rfm;
        logic [2:0]  mt;
        logic [1:0]  al;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] result;
        logic        csr_we;
        logic        csr_re;
        logic [13:0] csr_num;
        logic [31:0] wmask;
        logic [31:0] wvalue;
        logic        ertn;
        logic        syscall;
        logic [31:0] word;
    } instr_t;

    instr_t sbq[$];
    int     total = 0;
    int     bad = 0;
    bit     checkEn = 1'b0;
    bit     stimOcc = 1'b0;
    bit     lastAccept = 1'b0;
    logic [31:0] lastWord = 32'd0;

    // Monitor-only variables
    bit          hasItem;
    instr_t      cur;
    logic [31:0] fin;

    task automatic check(input string name, input logic [183:0] act, input logic [183:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [189:0] exBus(input instr_t i);
        return {i.gr_we, i.rfm, i.mt, i.al, i.dest, i.pc, i.inst, i.result,
                i.csr_we, i.csr_re, i.csr_num, i.wmask, i.wvalue, i.ertn, i.syscall};
    endfunction

    // Reference result computed from the load rules with plain arithmetic
    function automatic logic [31:0] expFinal(input instr_t i);
        logic [31:0] v;
        if (!i.rfm) return i.result;
        if (i.mt[1:0] == 2'b00) begin
            v = (i.word >> (8 * i.al)) & 32'hFF;
            if (!i.mt[2] && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (i.mt[1:0] == 2'b01) begin
            v = i.al[1] ? (i.word >> 16) : (i.word & 32'hFFFF);
            if (!i.mt[2] && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = i.word;
        end
        return v;
    endfunction

    function automatic logic [183:0] wbBus(input instr_t i);
        return {i.gr_we, i.dest, i.pc, i.inst, expFinal(i), i.csr_we, i.csr_re,
                i.csr_num, i.wmask, i.wvalue, i.ertn, i.syscall};
    endfunction

    function automatic instr_t randInstr();
        instr_t i;
        i.gr_we   = 1'($urandom);
        i.rfm     = 1'($urandom);
        i.mt      = 3'($urandom);
        i.al      = 2'($urandom);
        i.dest    = 5'($urandom);
        i.pc      = $urandom;
        i.inst    = $urandom;
        i.result  = $urandom;
        i.csr_we  = 1'($urandom);
        i.csr_re  = 1'($urandom);
        i.csr_num = 14'($urandom);
        i.wmask   = $urandom;
        i.wvalue  = $urandom;
        i.ertn    = ($urandom_range(0, 9) == 0);
        i.syscall = ($urandom_range(0, 9) == 0);
        i.word    = $urandom;
        return i;
    endfunction

    function automatic instr_t mkIns(input logic rfm, input logic [2:0] mt, input logic [1:0] al,
                                     input logic [31:0] word, input logic [31:0] result);
        instr_t i;
        i = randInstr();
        i.gr_we   = 1'b1;
        i.rfm     = rfm;
        i.mt      = mt;
        i.al      = al;
        i.word    = word;
        i.result  = result;
        i.ertn    = 1'b0;
        i.syscall = 1'b0;
        return i;
    endfunction

    // One clock cycle of stimulus. Inputs change 1 time unit after the rising
    // edge. The optional spot check of final_result happens mid-cycle. The
    // edge is then accounted for in the scoreboard.
    task automatic applyStimulus(input logic ev, input instr_t ins, input logic wa,
                                 input logic wex, input logic ef, input logic rn,
                                 input logic spotEn, input logic [31:0] spotVal);
        bit acceptNow;
        resetn          = rn;
        ex_mem_valid    = ev;
        ex_mem_bus      = exBus(ins);
        wb_allowin      = wa;
        wb_ex           = wex;
        ertn_flush      = ef;
        data_sram_rdata = lastAccept ? lastWord : $urandom;
        #2;
        if (spotEn) check("spot_final", 184'(mem_wb_bus[113:82]), 184'(spotVal));
        @(posedge clk);
        acceptNow = rn && !(wex || ef) && ev && (!stimOcc || wa);
        if (!rn || wex || ef) stimOcc = 1'b0;
        else if (acceptNow)   stimOcc = 1'b1;
        else if (wa)          stimOcc = 1'b0;
        if (acceptNow) sbq.push_back(ins);
        lastAccept = acceptNow;
        lastWord   = ins.word;
        #1;
    endtask

    // Monitor and scoreboard checker
    always @(negedge clk) begin
        if (checkEn) begin
            hasItem = (sbq.size() > 0);
            check("mem_wb_valid", 184'(mem_wb_valid), 184'(hasItem));
            check("mem_allowin", 184'(mem_allowin), 184'(!hasItem || wb_allowin));
            if (hasItem) begin
                cur = sbq[0];
                fin = expFinal(cur);
                check("mem_wb_bus", mem_wb_bus, wbBus(cur));
                check("mem_id_bus", 184'(mem_id_bus),
                      184'({cur.gr_we, cur.dest, fin, cur.csr_re, cur.csr_num}));
                check("mem_ex", 184'(mem_ex), 184'(cur.syscall | cur.ertn));
                if (!resetn || wb_allowin || wb_ex || ertn_flush) void'(sbq.pop_front());
            end else begin
                check("mem_ex_idle", 184'(mem_ex), 184'(0));
                check("bypass_idle", 184'(mem_id_bus[52]), 184'(0));
                check("csr_re_idle", 184'(mem_id_bus[14]), 184'(0));
            end
        end
        if (!resetn) sbq.delete();
    end

    initial begin
        instr_t idle, a, x, y, sc;
        idle = mkIns(1'b0, 3'b010, 2'b00, 32'd0, 32'd0);

        // Reset state
        applyStimulus(1'b0, idle, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, idle, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        checkEn = 1'b1;
        applyStimulus(1'b0, idle, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);

        // Load extension cases, back to back; each spot check covers the previous instruction
        applyStimulus(1'b1, mkIns(1'b1, 3'b000, 2'd2, 32'h1280_7F00, 32'd0), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, mkIns(1'b1, 3'b100, 2'd2, 32'h1280_7F00, 32'd0), 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FF80);
        applyStimulus(1'b1, mkIns(1'b1, 3'b001, 2'd2, 32'h8001_1234, 32'd0), 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0080);
        applyStimulus(1'b1, mkIns(1'b1, 3'b010, 2'd0, 32'h8001_1234, 32'd0), 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_8001);
        applyStimulus(1'b1, mkIns(1'b0, 3'b010, 2'd0, 32'd0, 32'hDEAD_BEEF), 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8001_1234);
        a = mkIns(1'b1, 3'b010, 2'd0, 32'hCAFE_F00D, 32'd0);
        applyStimulus(1'b1, a, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);

        // Stall: read data is only fresh in the first cycle
        x = mkIns(1'b0, 3'b010, 2'd0, 32'd0, 32'h1111_2222);
        repeat (4) applyStimulus(1'b1, x, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hCAFE_F00D);
        applyStimulus(1'b1, x, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hCAFE_F00D);

        // Syscall held, then a flush while execute offers another instruction
        sc = mkIns(1'b0, 3'b010, 2'd0, 32'd0, 32'h0000_0ACE);
        sc.syscall = 1'b1;
        applyStimulus(1'b1, sc, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1111_2222);
        y = mkIns(1'b1, 3'b000, 2'd1, 32'h0000_5500, 32'd0);
        applyStimulus(1'b1, y, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, y, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b0, idle, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);

        // Reset while a load is stalled in the stage
        applyStimulus(1'b1, mkIns(1'b1, 3'b001, 2'd0, 32'h0000_ABCD, 32'd0), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b0, idle, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_ABCD);
        applyStimulus(1'b0, idle, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b0, idle, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(0, 9) < 7), randInstr(),
                          ($urandom_range(0, 9) < 7),
                          ($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 99) != 0),
                          1'b0, 32'd0);
        end
        applyStimulus(1'b0, idle, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b0, idle, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
